// File: rtl/dnn_seq_pkg.sv
// Shared types and constants for the dnn_layer_seq codebase slice.
//   seq_state_e : layer sequencer FSM states
//   CORE_LAT    : MAC core latency from strobe to FMA stage (cycles)
//   BF16_ONE    : bf16 1.0, the operand the core pairs with the bias weight
//   FP32_ZERO   : fp32 +0.0, used for idle/ReLU-clamped output data
//   relu_fp32() : clamp negative fp32 values (sign bit set) to +0.0
package dnn_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_EXEC  = 3'd2,
    S_BIAS  = 3'd3,
    S_HOLD  = 3'd4,
    S_DRAIN = 3'd5
  } seq_state_e;

  localparam int          CORE_LAT  = 2;
  localparam logic [15:0] BF16_ONE  = 16'h3f80;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  function automatic logic [31:0] relu_fp32(input logic [31:0] v);
    return v[31] ? FP32_ZERO : v;
  endfunction

endpackage

// File: rtl/dnn_seq_out_stage.sv
// Output stage of the layer sequencer.
// Collects "bank final" events from the sequencer, issues nrm_en to the
// normalizer and presents the result on a valid/ready port.
//   clk, rst_n   : clock, asynchronous active-low reset
//   evt_i        : a neuron's accumulator bank is final this cycle
//   evt_idx_i    : neuron index of that event (bank = index bit 0)
//   nrm_i        : normalizer fp32 result (registered inside the normalizer)
//   out_ready_i  : consumer accepts out_data_o
//   nrm_en_o     : normalizer register enable
//   sum_op_o     : bank presented to the normalizer
//   out_valid_o  : out_data_o / out_idx_o valid
//   out_data_o   : fp32 result (ReLU-clamped when DNN_SEQ_RELU_EN is defined)
//   out_idx_o    : neuron index of out_data_o
// Handshake: a transfer happens on out_valid_o && out_ready_i; out_valid_o
// holds with stable data until that transfer. nrm_en_o never fires while
// out_valid_o && !out_ready_i, which keeps nrm_i (and so out_data_o) stable.
// Optional feature macro: DNN_SEQ_RELU_EN.
module dnn_seq_out_stage
  import dnn_seq_pkg::*;
#(
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          evt_i,
  input  logic [NW-1:0] evt_idx_i,
  input  logic [31:0]   nrm_i,
  input  logic          out_ready_i,
  output logic          nrm_en_o,
  output logic          sum_op_o,
  output logic          out_valid_o,
  output logic [31:0]   out_data_o,
  output logic [NW-1:0] out_idx_o
);

  // Pending-bank queue, depth 2: the sequencer never has more than two
  // neurons finished but not yet normalized.
  logic [1:0]    cnt_q, cnt_d;
  logic [NW-1:0] q0_q, q0_d, q1_q, q1_d;
  logic          out_valid_q, out_valid_d;
  logic [NW-1:0] out_idx_q, out_idx_d;

  logic          avail, fire, pop, push;
  logic [NW-1:0] head_idx;

  always_comb begin
    // An arriving event may go straight to the normalizer when the queue is empty.
    avail    = (cnt_q != 2'd0) || evt_i;
    head_idx = (cnt_q != 2'd0) ? q0_q : evt_idx_i;
    fire     = avail && (!out_valid_q || out_ready_i);
    pop      = fire && (cnt_q != 2'd0);
    push     = evt_i && !(fire && (cnt_q == 2'd0));

    q0_d  = q0_q;
    q1_d  = q1_q;
    cnt_d = cnt_q;
    if (pop) begin
      q0_d  = q1_q;
      cnt_d = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_d == 2'd0) q0_d = evt_idx_i;
      else               q1_d = evt_idx_i;
      cnt_d = cnt_d + 2'd1;
    end

    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    if (fire) begin
      out_valid_d = 1'b1;
      out_idx_d   = head_idx;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 2'd0;
      q0_q        <= '0;
      q1_q        <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      q0_q        <= q0_d;
      q1_q        <= q1_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign nrm_en_o    = fire;
  assign sum_op_o    = avail & head_idx[0];
  assign out_valid_o = out_valid_q;
  assign out_idx_o   = out_idx_q;

  // The normalizer output register doubles as the data register; gating with
  // valid keeps the port at zero whenever no result is offered.
`ifdef DNN_SEQ_RELU_EN
  assign out_data_o = out_valid_q ? relu_fp32(nrm_i) : FP32_ZERO;
`else
  assign out_data_o = out_valid_q ? nrm_i : FP32_ZERO;
`endif

endmodule

// File: rtl/dnn_layer_seq.sv
// Fully-connected layer sequencer for a single MAC core.
// Per neuron: INIT (init strobe), EXEC (n_in exec strobes, ra=0..n_in-1),
// BIAS (bias strobe); finished banks are handed to the output stage, which
// drives the normalizer. Banks ping-pong on neuron index bit 0.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle pulse, accepted only when idle
//   n_in, n_out : inputs per neuron / neurons per layer, latched on start
//   busy, done  : layer in progress / one-cycle completion pulse
//   init, exec, bias, ra : core strobes and read index
//   sum_ip      : accumulate bank aligned to the core FMA stage
//   sum_op, nrm_en, nrm  : normalizer bank select, enable, result
//   out_valid, out_ready, out_data, out_idx : result port
// Optional feature macro: DNN_SEQ_RELU_EN (ReLU on out_data).
module dnn_layer_seq
  import dnn_seq_pkg::*;
#(
  parameter int AW = 10,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] n_in,
  input  logic [NW-1:0] n_out,
  output logic          busy,
  output logic          done,
  output logic          init,
  output logic          exec,
  output logic          bias,
  output logic [AW-1:0] ra,
  output logic          sum_ip,
  output logic          sum_op,
  output logic          nrm_en,
  input  logic [31:0]   nrm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [NW-1:0] out_idx
);

  seq_state_e    state_q, state_d;
  logic          done_q, done_d;
  logic [AW-1:0] n_in_q, ra_q;
  logic [NW-1:0] n_out_q, nidx_q, nrm_cnt_q, acc_cnt_q;

  logic [CORE_LAT-1:0] bank_pipe_q;
  logic [CORE_LAT:0]   bias_pipe_q;
  logic [NW-1:0]       bidx_pipe_q [CORE_LAT+1];

  logic          start_ok, xfer, ra_last, last_neuron;
  logic [NW:0]   next_idx, nrm_done, acc_next;

  // Neuron jj may reuse its bank once neuron jj-2 has been normalized.
  function automatic logic gate_ok(input logic [NW:0] jj, input logic [NW:0] done_cnt);
    return (jj < (NW+1)'(2)) || ((done_cnt + (NW+1)'(1)) >= jj);
  endfunction

  assign start_ok    = start && (state_q == S_IDLE);
  assign xfer        = out_valid && out_ready;
  assign ra_last     = (ra_q == (n_in_q - AW'(1)));
  assign next_idx    = {1'b0, nidx_q} + (NW+1)'(1);
  assign last_neuron = (next_idx == {1'b0, n_out_q});
  // Count includes an nrm_en firing this very cycle.
  assign nrm_done    = {1'b0, nrm_cnt_q} + {{NW{1'b0}}, nrm_en};
  assign acc_next    = {1'b0, acc_cnt_q} + {{NW{1'b0}}, xfer};

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          if ((n_in == '0) || (n_out == '0)) done_d  = 1'b1;
          else                               state_d = S_INIT;
        end
      end
      S_INIT:  state_d = S_EXEC;
      S_EXEC:  if (ra_last) state_d = S_BIAS;
      S_BIAS: begin
        if (last_neuron)                     state_d = S_DRAIN;
        else if (gate_ok(next_idx, nrm_done)) state_d = S_INIT;
        else                                 state_d = S_HOLD;
      end
      S_HOLD:  if (gate_ok({1'b0, nidx_q}, nrm_done)) state_d = S_INIT;
      S_DRAIN: begin
        if (acc_next == {1'b0, n_out_q}) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    init = (state_q == S_INIT);
    exec = (state_q == S_EXEC);
    bias = (state_q == S_BIAS);
    busy = (state_q != S_IDLE);
    done = done_q;
    ra   = ra_q;
  end

  // Layer counters and latched sizes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_in_q    <= '0;
      n_out_q   <= '0;
      nidx_q    <= '0;
      ra_q      <= '0;
      nrm_cnt_q <= '0;
      acc_cnt_q <= '0;
    end else begin
      if (start_ok) begin
        n_in_q    <= n_in;
        n_out_q   <= n_out;
        nidx_q    <= '0;
        nrm_cnt_q <= '0;
        acc_cnt_q <= '0;
      end else begin
        if (nrm_en) nrm_cnt_q <= nrm_cnt_q + NW'(1);
        if (xfer)   acc_cnt_q <= acc_cnt_q + NW'(1);
        if ((state_q == S_BIAS) && !last_neuron) nidx_q <= nidx_q + NW'(1);
      end
      if (state_q == S_EXEC) ra_q <= ra_last ? '0 : ra_q + AW'(1);
    end
  end

  // Core alignment: the issue bank reaches the FMA stage CORE_LAT cycles
  // later; a bias strobe makes its bank final one cycle after that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_pipe_q <= '0;
      bias_pipe_q <= '0;
      for (int i = 0; i <= CORE_LAT; i++) bidx_pipe_q[i] <= '0;
    end else begin
      bank_pipe_q    <= {bank_pipe_q[CORE_LAT-2:0], nidx_q[0]};
      bias_pipe_q    <= {bias_pipe_q[CORE_LAT-1:0], bias};
      bidx_pipe_q[0] <= nidx_q;
      for (int i = 1; i <= CORE_LAT; i++) bidx_pipe_q[i] <= bidx_pipe_q[i-1];
    end
  end

  assign sum_ip = bank_pipe_q[CORE_LAT-1];

  dnn_seq_out_stage #(.NW(NW)) u_out (
    .clk         (clk),
    .rst_n       (rst_n),
    .evt_i       (bias_pipe_q[CORE_LAT]),
    .evt_idx_i   (bidx_pipe_q[CORE_LAT]),
    .nrm_i       (nrm),
    .out_ready_i (out_ready),
    .nrm_en_o    (nrm_en),
    .sum_op_o    (sum_op),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_idx_o   (out_idx)
  );

endmodule

// File: tb/tb_dnn_layer_seq.sv
module tb_dnn_layer_seq;

  localparam int AW = 10;
  localparam int NW = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] n_in = '0;
  logic [NW-1:0] n_out = '0;
  logic          out_ready = 1'b0;
  logic [31:0]   nrm = '0;
  logic          busy, done, init, exec, bias, sum_ip, sum_op, nrm_en, out_valid;
  logic [AW-1:0] ra;
  logic [31:0]   out_data;
  logic [NW-1:0] out_idx;

  always #5 clk = ~clk;

  dnn_layer_seq #(.AW(AW), .NW(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_in(n_in), .n_out(n_out),
    .busy(busy), .done(done), .init(init), .exec(exec), .bias(bias), .ra(ra),
    .sum_ip(sum_ip), .sum_op(sum_op), .nrm_en(nrm_en), .nrm(nrm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx)
  );

  // Normalizer model: on each enable it loads base + (neuron ordinal).
  logic        nrm_fire = 1'b0;
  logic [31:0] nrm_base = '0;
  int          nrm_k = 0;
  int          nrm_k0 = 0;
  always @(posedge clk) begin
    if (nrm_fire) begin
      nrm   <= nrm_base + 32'(nrm_k - nrm_k0);
      nrm_k <= nrm_k + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [31:0] v);
`ifdef DNN_SEQ_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int          n_in;
    int          n_out;
    int          stall;   // out_ready low this many cycles from first out_valid
    int          dup;     // cycle of an extra start pulse while busy, -1 none
    logic [31:0] base;    // normalizer value of neuron 0
    int          e_init;
    int          e_exec;
    int          e_fi;    // first init cycle (-1 none)
    int          e_fn;    // first nrm_en cycle
    int          e_fov;   // first out_valid cycle
    int          e_done;  // done pulse cycle
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input string tag);
    int rel = 0;
    int init_c = 0, exec_c = 0, bias_c = 0, done_c = 0, outs = 0;
    int fi = -1, fn = -1, fov = -1, fdone = -1;
    int ra_exp = 0, ra_bad = 0, sip_bad = 0, bank_bad = 0, stall_bad = 0;
    bit h1v = 0, h2v = 0, h1b = 0, h2b = 0;
    logic [47:0] exp_q[$];
    logic [47:0] got;
    logic [31:0] val;

    for (int k = 0; k < v.n_out && v.n_in > 0; k++) begin
      val = v.base + 32'(k);
      exp_q.push_back({NW'(k), exp_data(val)});
    end
    nrm_base = v.base;
    nrm_k0   = nrm_k;

    @(negedge clk);
    start     = 1'b1;
    n_in      = AW'(v.n_in);
    n_out     = NW'(v.n_out);
    out_ready = 1'b1;

    while (rel < 400 && !(fdone >= 0 && rel >= fdone + 3)) begin
      @(negedge clk);
      rel++;
      // drive this cycle
      start = (rel == v.dup);
      n_in  = AW'($urandom_range(0, 7));
      n_out = NW'($urandom_range(0, 7));
      if (out_valid && fov < 0) fov = rel;
      out_ready = !(v.stall > 0 && fov >= 0 && rel >= fov && rel < fov + v.stall);
      #1;
      // sample this cycle
      if (init) begin
        init_c++;
        ra_exp = 0;
        if (fi < 0) fi = rel;
      end
      if (exec) begin
        exec_c++;
        if (int'(ra) != ra_exp) ra_bad++;
        ra_exp++;
      end
      if (bias) bias_c++;
      if (h2v && (sum_ip != h2b)) sip_bad++;
      h2v = h1v;
      h2b = h1b;
      h1v = init | exec | bias;
      h1b = 1'((init_c - 1) & 1);
      nrm_fire = nrm_en;
      if (nrm_en) begin
        if (fn < 0) fn = rel;
        if (out_valid && !out_ready) stall_bad++;
        if (sum_op != 1'((nrm_k - nrm_k0) & 1)) bank_bad++;
      end
      if (out_valid && out_ready) begin
        outs++;
        got = {out_idx, out_data};
        if (exp_q.size() == 0) chk({tag, " extra_out"}, 64'(got), 64'hdead);
        else chk({tag, " out_idx_data"}, 64'(got), 64'(exp_q.pop_front()));
      end
      if (done) begin
        done_c++;
        if (fdone < 0) fdone = rel;
      end
    end
    nrm_fire  = 1'b0;
    start     = 1'b0;

    chk({tag, " init_count"}, 64'(init_c), 64'(v.e_init));
    chk({tag, " exec_count"}, 64'(exec_c), 64'(v.e_exec));
    chk({tag, " bias_count"}, 64'(bias_c), 64'(v.e_init));
    chk({tag, " first_init"}, 64'(fi), 64'(v.e_fi));
    chk({tag, " first_nrm_en"}, 64'(fn), 64'(v.e_fn));
    chk({tag, " first_out_valid"}, 64'(fov), 64'(v.e_fov));
    chk({tag, " done_cycle"}, 64'(fdone), 64'(v.e_done));
    chk({tag, " done_pulses"}, 64'(done_c), 64'd1);
    chk({tag, " out_count"}, 64'(outs), 64'(v.n_in > 0 ? v.n_out : 0));
    chk({tag, " ra_sequence"}, 64'(ra_bad), 64'd0);
    chk({tag, " sum_ip_align"}, 64'(sip_bad), 64'd0);
    chk({tag, " sum_op_bank"}, 64'(bank_bad), 64'd0);
    chk({tag, " nrm_en_stall"}, 64'(stall_bad), 64'd0);
    chk({tag, " busy_after"}, 64'(busy), 64'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    //          n_in n_out stall dup base           init exec fi fn  fov done
    vecs[0] = '{3,   1,    0,   -1, 32'h40D0_0000, 1,   3,   1, 8,  9,  10};
    vecs[1] = '{3,   1,    0,    3, 32'hC0C0_0000, 1,   3,   1, 8,  9,  10};
    vecs[2] = '{2,   4,    0,   -1, 32'h3F80_0000, 4,   8,   1, 7,  8,  21};
    vecs[3] = '{2,   4,    20,  -1, 32'h4100_0000, 4,   8,   1, 7,  8,  37};
    vecs[4] = '{5,   0,    0,   -1, 32'h0,         0,   0,  -1, -1, -1, 1};
    vecs[5] = '{0,   3,    0,   -1, 32'h0,         0,   0,  -1, -1, -1, 1};

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        64'({busy, done, init, exec, bias, ra, sum_ip, sum_op, nrm_en, out_valid, out_data, out_idx}),
        64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // reset mid-EXEC abandons the layer
    @(negedge clk);
    start = 1'b1; n_in = AW'(5); n_out = NW'(2); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_exec_strobe", 64'(exec), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        64'({busy, done, init, exec, bias, ra, sum_ip, sum_op, nrm_en, out_valid, out_data, out_idx}),
        64'd0);
    repeat (2) @(negedge clk);
    chk("no_done_in_reset", 64'(done), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(vecs[0], "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
